// File: rtl/uart_hex_pkg.sv
// Shared constants, mode type and hex digit decoding for the UART hex loader.
package uart_hex_pkg;

    localparam logic [7:0] CH_AT    = 8'h40;
    localparam logic [7:0] CH_HASH  = 8'h23;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_COMMA = 8'h2C;

    typedef enum logic {
        MODE_DATA = 1'b0,
        MODE_ADDR = 1'b1
    } mode_t;

    // Returns {valid, nibble}; valid is 0 for any non-hex byte.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        r = 5'b0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, b[3:0]};
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            r = {1'b1, b[3:0] + 4'd9};
        end
        return r;
    endfunction

    function automatic logic is_sep(input logic [7:0] b);
        return (b == CH_SP) || (b == CH_CR) || (b == CH_LF) || (b == CH_COMMA);
    endfunction

endpackage

// File: rtl/hex_resp_fifo.sv
// Two-entry byte FIFO for loader responses; push2 lands behind push in the same cycle.
module hex_resp_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       push2,
    input  logic [7:0] push2_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    logic [7:0] mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign rd_data = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q + {1'b0, push} + {1'b0, push2} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
            if (push2) begin
                mem_q[wr_ptr_q ^ push] <= push2_data;
            end
            wr_ptr_q <= wr_ptr_q ^ push ^ push2;
            rd_ptr_q <= rd_ptr_q ^ do_pop;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_hex_loader.sv
// Hex-ASCII word loader between a UART byte stream and a memory write port.
// Define UART_HEX_LOADER_ECHO_EN to echo every accepted byte ahead of its ACK/NAK.
module uart_hex_loader
    import uart_hex_pkg::*;
#(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter logic [7:0]  ACK_CHAR = 8'h2E,
    parameter logic [7:0]  NAK_CHAR = 8'h3F
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [WORD_W-1:0]          wr_data,
    output logic [$clog2(WORD_W/4):0]  nib_cnt,
    output logic                       addr_mode,
    output logic                       err
);

    localparam int unsigned NW = $clog2(WORD_W / 4) + 1;
    localparam logic [NW-1:0] LAST_NIB = NW'(WORD_W / 4 - 1);

    // Reset asserts asynchronously but releases two clocks after rst_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    mode_t             mode_q, mode_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [NW-1:0]     nib_cnt_q, nib_cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
    logic              addr_any_q, addr_any_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;

    logic              accept;
    logic              dig_ok;
    logic [3:0]        nib;
    logic [ADDR_W+3:0] addr_ext;
    logic              resp_push;
    logic [7:0]        resp_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic [7:0]        fifo_push_data;
    logic              fifo_push2;
    logic [7:0]        fifo_push2_data;

    assign {dig_ok, nib} = hex_decode(rx_data);
    assign addr_ext      = {addr_sr_q, nib};
    assign rx_ready      = rst_int_n && fifo_empty && !fifo_full && !wr_en_q;
    assign accept        = rx_valid && rx_ready;

    always_comb begin
        mode_d     = mode_q;
        acc_d      = acc_q;
        nib_cnt_d  = nib_cnt_q;
        ptr_d      = ptr_q;
        addr_sr_d  = addr_sr_q;
        addr_any_d = addr_any_q;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        resp_push  = 1'b0;
        resp_data  = ACK_CHAR;
        if (accept) begin
            if (rx_data == CH_HASH) begin
                mode_d     = MODE_DATA;
                acc_d      = '0;
                nib_cnt_d  = '0;
                ptr_d      = '0;
                addr_sr_d  = '0;
                addr_any_d = 1'b0;
                err_d      = 1'b0;
            end else if (mode_q == MODE_DATA && dig_ok) begin
                acc_d = {acc_q[WORD_W-5:0], nib};
                if (nib_cnt_q == LAST_NIB) begin
                    nib_cnt_d = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = {acc_q[WORD_W-5:0], nib};
                    ptr_d     = ptr_q + ADDR_W'(1);
                    resp_push = 1'b1;
                end else begin
                    nib_cnt_d = nib_cnt_q + NW'(1);
                end
            end else if (mode_q == MODE_DATA && rx_data == CH_AT && nib_cnt_q == '0) begin
                mode_d     = MODE_ADDR;
                addr_sr_d  = '0;
                addr_any_d = 1'b0;
            end else if (mode_q == MODE_DATA && is_sep(rx_data) && nib_cnt_q == '0) begin
                mode_d = MODE_DATA;
            end else if (mode_q == MODE_ADDR && dig_ok) begin
                addr_sr_d  = addr_ext[ADDR_W-1:0];
                addr_any_d = 1'b1;
            end else if (mode_q == MODE_ADDR && is_sep(rx_data)) begin
                if (addr_any_q) begin
                    ptr_d = addr_sr_q;
                end
                mode_d = MODE_DATA;
            end else begin
                mode_d    = MODE_DATA;
                nib_cnt_d = '0;
                err_d     = 1'b1;
                resp_push = 1'b1;
                resp_data = NAK_CHAR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            mode_q     <= MODE_DATA;
            acc_q      <= '0;
            nib_cnt_q  <= '0;
            ptr_q      <= '0;
            addr_sr_q  <= '0;
            addr_any_q <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            nib_cnt_q  <= nib_cnt_d;
            ptr_q      <= ptr_d;
            addr_sr_q  <= addr_sr_d;
            addr_any_q <= addr_any_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

`ifdef UART_HEX_LOADER_ECHO_EN
    assign fifo_push       = accept;
    assign fifo_push_data  = rx_data;
    assign fifo_push2      = resp_push;
    assign fifo_push2_data = resp_data;
`else
    assign fifo_push       = resp_push;
    assign fifo_push_data  = resp_data;
    assign fifo_push2      = 1'b0;
    assign fifo_push2_data = 8'h00;
`endif

    hex_resp_fifo u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_int_n),
        .push       (fifo_push),
        .push_data  (fifo_push_data),
        .push2      (fifo_push2),
        .push2_data (fifo_push2_data),
        .pop        (tx_valid && tx_ready),
        .rd_data    (tx_data),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign tx_valid  = !fifo_empty;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign nib_cnt   = nib_cnt_q;
    assign addr_mode = (mode_q == MODE_ADDR);
    assign err       = err_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Self-checking bench for uart_hex_loader: byte-level vector table plus hand-written
// backpressure and mid-word reset sequences.
module tb_uart_hex_loader;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 8;
`ifdef UART_HEX_LOADER_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [3:0]        nib_cnt;
    logic              addr_mode;
    logic              err;

    uart_hex_loader #(
        .WORD_W   (WORD_W),
        .ADDR_W   (ADDR_W),
        .ACK_CHAR (8'h2E),
        .NAK_CHAR (8'h3F)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .nib_cnt   (nib_cnt),
        .addr_mode (addr_mode),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ch;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  resp;   // 0 means no response byte
        logic        err;
        logic [3:0]  nib;
        logic        mode;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned step = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic [7:0] ch, input logic [7:0] resp, input logic e,
                       input logic [3:0] nib, input logic mode);
        vecs.push_back('{ch: ch, wr: 1'b0, addr: 8'h00, data: 32'h0, resp: resp,
                         err: e, nib: nib, mode: mode});
    endtask

    task automatic add_word(input string s, input logic [7:0] addr, input logic [31:0] data);
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{ch: s[i], wr: (i == 7), addr: (i == 7) ? addr : 8'h00,
                             data: (i == 7) ? data : 32'h0, resp: (i == 7) ? 8'h2E : 8'h00,
                             err: 1'b0, nib: (i == 7) ? 4'd0 : 4'(i + 1), mode: 1'b0});
        end
    endtask

    // Returns positioned 1 time unit after the accepting edge.
    task automatic send_raw(input logic [7:0] ch, output logic ok);
        int w;
        w = 0;
        @(negedge clk);
        while (!rx_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        ok = rx_ready;
        if (!ok) begin
            check("rx_ready_timeout", 64'd0, 64'd1);
            return;
        end
        rx_valid = 1'b1;
        rx_data  = ch;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        logic        ok;
        logic [1:0]  ntx;
        logic [15:0] txb;
        logic [1:0]  nwr;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [1:0]  en;
        logic [15:0] eb;
        bit          done;
        step++;
        send_raw(v.ch, ok);
        if (!ok) return;
        check($sformatf("state[%0d]", step), {err, nib_cnt, addr_mode}, {v.err, v.nib, v.mode});
        ntx = 0; txb = 0; nwr = 0; wa = 0; wd = 0; done = 0;
        for (int c = 0; c < 8 && !done; c++) begin
            if (tx_valid && tx_ready) begin
                txb = {txb[7:0], tx_data};
                ntx++;
            end
            if (wr_en) begin
                nwr++;
                wa = wr_addr;
                wd = wr_data;
            end
            if (rx_ready) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check($sformatf("settle_timeout[%0d]", step), 64'd0, 64'd1);
        en = 0; eb = 0;
        if (ECHO) begin
            eb = {eb[7:0], v.ch};
            en++;
        end
        if (v.resp != 8'h00) begin
            eb = {eb[7:0], v.resp};
            en++;
        end
        check($sformatf("tx[%0d]", step), {ntx, txb}, {en, eb});
        check($sformatf("wr[%0d]", step), {nwr, wa, wd},
              v.wr ? {2'd1, v.addr, v.data} : 42'd0);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();
    endtask

    function automatic logic [63:0] all_outs();
        return {7'd0, rx_ready, tx_valid, tx_data, wr_en, wr_addr, wr_data, nib_cnt,
                addr_mode, err};
    endfunction

    initial begin
        logic       ok;
        bit         stable;
        string      bp;
        logic [7:0] bp_head;
        int         bp_pops;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main table.
        add_word("DEADBEEF", 8'h00, 32'hDEADBEEF);
        add_word("01234567", 8'h01, 32'h01234567);
        add("@", 8'h00, 0, 4'd0, 1); add("1", 8'h00, 0, 4'd0, 1);
        add("F", 8'h00, 0, 4'd0, 1); add(" ", 8'h00, 0, 4'd0, 0);
        add_word("cafef00d", 8'h1F, 32'hCAFEF00D);
        add_word("11111111", 8'h20, 32'h11111111);
        add("@", 8'h00, 0, 4'd0, 1); add("F", 8'h00, 0, 4'd0, 1);
        add("F", 8'h00, 0, 4'd0, 1); add(8'h0D, 8'h00, 0, 4'd0, 0);
        add_word("00000002", 8'hFF, 32'h00000002);
        add_word("00000003", 8'h00, 32'h00000003);
        add(8'h0A, 8'h00, 0, 4'd0, 0);
        add("1", 8'h00, 0, 4'd1, 0); add("2", 8'h00, 0, 4'd2, 0);
        add(" ", 8'h3F, 1, 4'd0, 0);
        add("G", 8'h3F, 1, 4'd0, 0);
        add("5", 8'h00, 1, 4'd1, 0); add("@", 8'h3F, 1, 4'd0, 0);
        add("@", 8'h00, 1, 4'd0, 1); add("x", 8'h3F, 1, 4'd0, 0);
        add("#", 8'h00, 0, 4'd0, 0);
        add_word("00000009", 8'h00, 32'h00000009);
        add("@", 8'h00, 0, 4'd0, 1); add(",", 8'h00, 0, 4'd0, 0);
        add_word("0000000a", 8'h01, 32'h0000000A);
        add("@", 8'h00, 0, 4'd0, 1); add("1", 8'h00, 0, 4'd0, 1);
        add("2", 8'h00, 0, 4'd0, 1); add("3", 8'h00, 0, 4'd0, 1);
        add(" ", 8'h00, 0, 4'd0, 0);
        add_word("FFFFFFFF", 8'h23, 32'hFFFFFFFF);
        run_vecs();

        // Backpressure: response held, acceptance blocked until the queue drains.
        bp_head = ECHO ? 8'h46 : 8'h2E;
        bp_pops = ECHO ? 2 : 1;
        tx_ready = 1'b0;
        bp = "0000BEEF";
        for (int i = 0; i < 8; i++) send_raw(bp[i], ok);
        check("bp_wr", {wr_en, wr_addr, wr_data}, {1'b1, 8'h24, 32'h0000BEEF});
        rx_data  = "7";
        rx_valid = 1'b1;
        stable = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (!(tx_valid && tx_data == bp_head && !rx_ready && nib_cnt == 4'd0)) stable = 0;
        end
        check("bp_hold", {63'd0, stable}, 64'd1);
        tx_ready = 1'b1;
        for (int p = 0; p < bp_pops; p++) begin
            @(posedge clk);
            #1;
        end
        check("bp_release", {rx_ready, nib_cnt}, {1'b1, 4'd0});
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("bp_accept", {60'd0, nib_cnt}, 64'd1);

        add("#", 8'h00, 0, 4'd0, 0);
        add("A", 8'h00, 0, 4'd1, 0); add("B", 8'h00, 0, 4'd2, 0);
        add("C", 8'h00, 0, 4'd3, 0);
        run_vecs();

        // Asynchronous reset in the middle of a word.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midword_reset", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        add_word("00000001", 8'h00, 32'h00000001);
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
